// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
// Fetch/decode/execute sequencer for the accumulator CPU: one control word per T-state.
// Strobes are combinational from state, IR and mem_ready; memory steps hold while mem_ready=0.
module instr_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mem_ready,
  input  logic              zero_flag,
  output logic              pc_inc,
  output logic              pc_oe,
  output logic              pc_jmp,
  output logic              mar_ld,
  output logic              ram_oe,
  output logic              ram_we,
  output logic              ir_ld,
  output logic              ir_oe,
  output logic              a_ld,
  output logic              a_oe,
  output logic              b_ld,
  output logic              alu_oe,
  output logic              alu_sub,
  output logic              out_ld,
  output logic [2:0]        tstate,
  output logic [3:0]        opcode,
  output logic              halted
);

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            state, nxt;
  logic [DATA_W-1:0] ir;
  logic [3:0]        fetch_op;
  logic              mem_step;
  logic              unused_operand;

  assign opcode         = ir[DATA_W-1:DATA_W-4];
  assign fetch_op       = bus_in[DATA_W-1:DATA_W-4];
  assign unused_operand = ^ir[ADDR_W-1:0];
  assign tstate         = clr_n ? state : 3'd0;
  assign halted         = clr_n && (state == HALT);

  always_comb begin
    pc_inc   = 1'b0;
    pc_oe    = 1'b0;
    pc_jmp   = 1'b0;
    mar_ld   = 1'b0;
    ram_oe   = 1'b0;
    ram_we   = 1'b0;
    ir_ld    = 1'b0;
    ir_oe    = 1'b0;
    a_ld     = 1'b0;
    a_oe     = 1'b0;
    b_ld     = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    out_ld   = 1'b0;
    mem_step = 1'b0;
    nxt      = state;
    case (state)
      T0: begin
        pc_oe  = 1'b1;
        mar_ld = 1'b1;
        nxt    = T1;
      end
      T1: begin
        ram_oe   = 1'b1;
        ir_ld    = 1'b1;
        pc_inc   = 1'b1;
        mem_step = 1'b1;
        // IR is still the old instruction here, so branch on the word being latched
        case (fetch_op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
          OP_JMP, OP_JZ, OP_OUT, OP_HLT: nxt = T2;
          default:                       nxt = T0;
        endcase
      end
      T2: begin
        nxt = T0;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ir_oe  = 1'b1;
            mar_ld = 1'b1;
            nxt    = T3;
          end
          OP_LDI: begin
            ir_oe = 1'b1;
            a_ld  = 1'b1;
          end
          OP_JMP: begin
            ir_oe  = 1'b1;
            pc_jmp = 1'b1;
          end
          OP_JZ: begin
            ir_oe  = zero_flag;
            pc_jmp = zero_flag;
          end
          OP_OUT: begin
            a_oe   = 1'b1;
            out_ld = 1'b1;
          end
          OP_HLT:  nxt = HALT;
          default: nxt = T0;
        endcase
      end
      T3: begin
        mem_step = 1'b1;
        nxt      = T0;
        case (opcode)
          OP_LDA: begin
            ram_oe = 1'b1;
            a_ld   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_oe = 1'b1;
            b_ld   = 1'b1;
            nxt    = T4;
          end
          OP_STA: begin
            a_oe   = 1'b1;
            ram_we = 1'b1;
          end
          default: mem_step = 1'b0;
        endcase
      end
      T4: begin
        alu_oe  = 1'b1;
        a_ld    = 1'b1;
        alu_sub = (opcode == OP_SUB);
        nxt     = T0;
      end
      HALT:    nxt = HALT;
      default: nxt = T0;
    endcase

    if (mem_step && !mem_ready) begin
      ir_ld  = 1'b0;
      a_ld   = 1'b0;
      b_ld   = 1'b0;
      ram_we = 1'b0;
      pc_inc = 1'b0;
      nxt    = state;
    end

    // Reset must kill strobes between edges, not just at the next clock
    if (!clr_n) begin
      pc_inc  = 1'b0;
      pc_oe   = 1'b0;
      pc_jmp  = 1'b0;
      mar_ld  = 1'b0;
      ram_oe  = 1'b0;
      ram_we  = 1'b0;
      ir_ld   = 1'b0;
      ir_oe   = 1'b0;
      a_ld    = 1'b0;
      a_oe    = 1'b0;
      b_ld    = 1'b0;
      alu_oe  = 1'b0;
      alu_sub = 1'b0;
      out_ld  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= nxt;
      if (ir_ld) ir <= bus_in;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
`timescale 1ns/1ps
// Bench for instr_sequencer: per-instruction model of the expected control-word stream,
// checked every cycle on the falling edge, plus a few literal spot checks.
module tb_instr_sequencer;

  typedef logic [13:0] word_t;

  localparam word_t PC_INC  = 14'h2000;
  localparam word_t PC_OE   = 14'h1000;
  localparam word_t PC_JMP  = 14'h0800;
  localparam word_t MAR_LD  = 14'h0400;
  localparam word_t RAM_OE  = 14'h0200;
  localparam word_t RAM_WE  = 14'h0100;
  localparam word_t IR_LD   = 14'h0080;
  localparam word_t IR_OE   = 14'h0040;
  localparam word_t A_LD    = 14'h0020;
  localparam word_t A_OE    = 14'h0010;
  localparam word_t B_LD    = 14'h0008;
  localparam word_t ALU_OE  = 14'h0004;
  localparam word_t ALU_SUB = 14'h0002;
  localparam word_t OUT_LD  = 14'h0001;
  localparam word_t HOLD_MASK = PC_INC | IR_LD | A_LD | B_LD | RAM_WE;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       mem_ready = 1'b1;
  logic       zero_flag = 1'b0;
  logic [7:0] bus_in = 8'h00;

  logic pc_inc, pc_oe, pc_jmp, mar_ld, ram_oe, ram_we, ir_ld, ir_oe;
  logic a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld, halted;
  logic [2:0] tstate;
  logic [3:0] opcode;
  word_t ctl;

  assign ctl = {pc_inc, pc_oe, pc_jmp, mar_ld, ram_oe, ram_we, ir_ld, ir_oe,
                a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld};

  instr_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .clr_n(clr_n), .bus_in(bus_in), .mem_ready(mem_ready), .zero_flag(zero_flag),
    .pc_inc(pc_inc), .pc_oe(pc_oe), .pc_jmp(pc_jmp), .mar_ld(mar_ld), .ram_oe(ram_oe),
    .ram_we(ram_we), .ir_ld(ir_ld), .ir_oe(ir_oe), .a_ld(a_ld), .a_oe(a_oe), .b_ld(b_ld),
    .alu_oe(alu_oe), .alu_sub(alu_sub), .out_ld(out_ld), .tstate(tstate), .opcode(opcode),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  word_t      exp_ctl = '0;
  logic [2:0] exp_ts = 3'd0;
  logic       exp_h = 1'b0;
  logic [3:0] exp_op = 4'h0;
  logic       exp_vld = 1'b0;
  logic [7:0] m_ir = 8'h00;
  word_t      steps[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  always @(negedge clk) begin
    if (exp_vld) begin
      chk("ctl",    16'(ctl),    16'(exp_ctl));
      chk("tstate", 16'(tstate), 16'(exp_ts));
      chk("halted", 16'(halted), 16'(exp_h));
      chk("opcode", 16'(opcode), 16'(exp_op));
    end
  end

  task automatic cycle(input word_t w, input logic [2:0] ts, input logic h,
                       input logic mr, input logic zf, input logic [7:0] bus);
    mem_ready = mr;
    zero_flag = zf;
    bus_in    = bus;
    exp_ctl   = w;
    exp_ts    = ts;
    exp_h     = h;
    exp_op    = m_ir[7:4];
    exp_vld   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Execute-phase control words from T2 onward for each opcode
  task automatic build(input logic [3:0] op, input logic zf);
    steps.delete();
    case (op)
      4'h1: begin steps.push_back(IR_OE | MAR_LD); steps.push_back(RAM_OE | A_LD); end
      4'h2: begin
        steps.push_back(IR_OE | MAR_LD); steps.push_back(RAM_OE | B_LD);
        steps.push_back(ALU_OE | A_LD);
      end
      4'h3: begin
        steps.push_back(IR_OE | MAR_LD); steps.push_back(RAM_OE | B_LD);
        steps.push_back(ALU_OE | A_LD | ALU_SUB);
      end
      4'h4: begin steps.push_back(IR_OE | MAR_LD); steps.push_back(A_OE | RAM_WE); end
      4'h5: steps.push_back(IR_OE | A_LD);
      4'h6: steps.push_back(IR_OE | PC_JMP);
      4'h7: steps.push_back(zf ? (IR_OE | PC_JMP) : word_t'(0));
      4'hE: steps.push_back(A_OE | OUT_LD);
      4'hF: steps.push_back(word_t'(0));
      default: ;
    endcase
  endtask

  task automatic do_reset(input int n);
    clr_n = 1'b0;
    m_ir  = 8'h00;
    for (int i = 0; i < n; i++) cycle('0, 3'd0, 1'b0, 1'b1, 1'b0, 8'hA5);
    clr_n = 1'b1;
  endtask

  task automatic abort(input word_t w, input logic [2:0] ts, input logic zf);
    mem_ready = 1'b1;
    zero_flag = zf;
    bus_in    = 8'hA5;
    exp_vld   = 1'b0;
    #1;
    chk("abort_pre_ctl", 16'(ctl), 16'(w));
    chk("abort_pre_ts", 16'(tstate), 16'(ts));
    #1;
    clr_n = 1'b0;
    #1;
    chk("abort_ctl", 16'(ctl), 16'h0000);
    chk("abort_ts", 16'(tstate), 16'h0000);
    chk("abort_opcode", 16'(opcode), 16'h0000);
    m_ir    = 8'h00;
    exp_ctl = '0;
    exp_ts  = 3'd0;
    exp_h   = 1'b0;
    exp_op  = 4'h0;
    exp_vld = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [7:0] op8, input logic zf, input int st1, input int stm,
                       input int abort_k = -1);
    logic  idle_mr;
    word_t w;
    // Non-memory steps see mem_ready=0 whenever stalls are requested: they must not hold
    idle_mr = (st1 == 0 && stm == 0);
    cycle(PC_OE | MAR_LD, 3'd0, 1'b0, idle_mr, zf, 8'hA5);
    for (int i = 0; i < st1; i++) cycle(RAM_OE, 3'd1, 1'b0, 1'b0, zf, 8'hEE);
    cycle(RAM_OE | IR_LD | PC_INC, 3'd1, 1'b0, 1'b1, zf, op8);
    m_ir = op8;
    build(op8[7:4], zf);
    foreach (steps[k]) begin
      w = steps[k];
      if (k == abort_k) begin
        abort(w, 3'(k + 2), zf);
        return;
      end
      if ((w & (RAM_OE | RAM_WE)) != 0) begin
        for (int i = 0; i < stm; i++) cycle(w & ~HOLD_MASK, 3'(k + 2), 1'b0, 1'b0, zf, 8'hA5);
        cycle(w, 3'(k + 2), 1'b0, 1'b1, zf, 8'hA5);
      end else begin
        cycle(w, 3'(k + 2), 1'b0, idle_mr, zf, 8'hA5);
      end
    end
    if (op8[7:4] == 4'hF)
      for (int i = 0; i < 20; i++) cycle('0, 3'd7, 1'b1, i[0], zf, 8'hA5);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    instr(8'h00, 1'b0, 0, 0);
    instr(8'h00, 1'b0, 0, 0);
    instr(8'h00, 1'b0, 0, 0);

    instr(8'h1C, 1'b0, 0, 0);
    chk("lda_opcode", 16'(opcode), 16'h0001);
    chk("t0_after_lda", 16'(ctl), 16'h1400);

    instr(8'h7A, 1'b0, 0, 0);
    instr(8'h7A, 1'b1, 0, 0);
    chk("t0_after_jz", 16'(tstate), 16'h0000);

    instr(8'h1C, 1'b0, 3, 0);
    instr(8'h93, 1'b0, 3, 0);
    chk("stalled_fetch_opcode", 16'(opcode), 16'h0009);

    instr(8'h2A, 1'b0, 0, 2);
    instr(8'h3B, 1'b0, 0, 0);
    instr(8'h45, 1'b0, 1, 1);
    instr(8'h57, 1'b0, 0, 0);
    instr(8'h63, 1'b0, 0, 0);
    instr(8'hE0, 1'b0, 0, 0);
    chk("out_opcode", 16'(opcode), 16'h000E);

    instr(8'h2B, 1'b0, 0, 0, 1);
    do_reset(1);
    instr(8'h00, 1'b0, 0, 0);

    instr(8'hF0, 1'b0, 0, 0);
    chk("halt_flag", 16'(halted), 16'h0001);
    chk("halt_tstate", 16'(tstate), 16'h0007);
    do_reset(2);
    instr(8'h00, 1'b0, 0, 0);
    instr(8'h57, 1'b0, 0, 0);

    exp_vld = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
